count_checker: RTL
==================

# count_checker

Receive-side partner of the on-chip free-running counter. It samples an 8-bit count stream arriving on the dedicated inputs, usually from a second part driving its counter outputs, and locks onto a monotonically incrementing sequence. Once locked it flags every out-of-sequence sample and keeps a saturating error tally. It sits between `ui_in` and the status outputs of the top-level wrapper.

## Interface
Parameters:
- `WIDTH`, 8: width of the count stream.
- `LOCK_COUNT`, 4: consecutive +1 steps required to declare lock (≥1).
- `ERR_WIDTH`, 8: width of the error counter.
- `LOSS_THRESHOLD`, 3: consecutive mismatches that drop lock. Used only with the auto-relock feature.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `count_in` input WIDTH: incoming count value.
- `sample_en` input 1: `count_in` is valid this cycle.
- `clear` input 1: synchronous; zero `err_count` and return to SEARCH.
- `locked` output 1: sequence lock achieved.
- `err_pulse` output 1: one-cycle pulse per mismatch while locked.
- `err_count` output ERR_WIDTH: saturating mismatch count.
- `expected` output WIDTH: next value predicted while locked.

## Operation
Input stage:
- `count_in` and `sample_en` are registered on every edge into `s_count` and `s_valid`.
- All decisions use the registered copies.
- `prev` holds the last valid sample.

State machine (SEARCH, LOCKING, LOCKED). A state only changes when `s_valid` is 1.
- **SEARCH**: `prev` ← `s_count`, `match_cnt` ← 0, go to LOCKING.
- **LOCKING**:
  - If `s_count == prev + 1` (mod 2^WIDTH), increment `match_cnt`. When it reaches LOCK_COUNT, go to LOCKED with `expected` ← `s_count + 1`.
  - Otherwise clear `match_cnt` and stay in LOCKING.
  - `prev` ← `s_count` in both cases.
- **LOCKED**:
  - Match (`s_count == expected`): `miss_cnt` ← 0.
  - Mismatch: assert `err_pulse`, increment `err_count` (saturating at all-ones), increment `miss_cnt`.
  - In both cases `expected` ← `s_count + 1`, i.e. resync to the received value. A single glitch therefore costs exactly one error.

Other rules:
- `locked` is 1 exactly when the state is LOCKED.
- `clear` takes priority over a simultaneous valid sample. It zeroes `err_count`, `match_cnt` and `miss_cnt`, sets state to SEARCH, and suppresses `err_pulse` that cycle.
- Asynchronous reset mid-operation immediately forces every register to its reset value.
- All arithmetic is modulo 2^WIDTH, so 0xFF → 0x00 is a valid step.

Reset values: state SEARCH, `locked` 0, `err_pulse` 0, `err_count` 0, `expected` 0, `prev` 0, `s_count` 0, `s_valid` 0.

## Timing
- Latency: a sample presented with `sample_en` before edge k is evaluated at edge k+1. `err_pulse`, `locked` and `expected` reflect it after edge k+1, i.e. two edges after presentation.
- `err_pulse` is high for exactly one cycle per mismatching sample. Back-to-back mismatches give back-to-back pulses.
- `sample_en` may be held high continuously or gapped arbitrarily. Gaps do not advance `expected`.
- `clear` acts on the edge where it is sampled high; there is no input register on `clear`.

## Configuration
- `COUNT_CHECK_AUTORELOCK_EN` defined: in LOCKED, when `miss_cnt` reaches LOSS_THRESHOLD, go to SEARCH. `locked` drops on that same edge, and the `err_pulse` for that sample is still issued.
- Not defined: LOCKED is left only via `clear` or reset. `miss_cnt` is not implemented and LOSS_THRESHOLD is ignored.

## Structure
- Package `count_check_pkg`: state enum (SEARCH, LOCKING, LOCKED) and default values of WIDTH, LOCK_COUNT, ERR_WIDTH, LOSS_THRESHOLD.
- One sub-module, `sat_counter`: parameterised width, synchronous clear, increment enable, saturates at all-ones. It is instantiated for `err_count`.
- Input register, FSM and compare logic live in `count_checker`.

## Test plan
All scenarios use WIDTH=8 and LOCK_COUNT=4.
- **Lock acquisition**: release reset, feed 0x10, 0x11, 0x12, 0x13, 0x14 with `sample_en` continuous → `locked` rises 2 edges after 0x14 is presented; `expected`=0x15; `err_count`=0.
- **Wrap-around**: once locked, feed 0xFD, 0xFE, 0xFF, 0x00, 0x01 contiguously → no `err_pulse`; `expected`=0x02.
- **Single glitch**: locked with `expected`=0x20, feed 0x20, 0x55, 0x56, 0x57 → exactly one `err_pulse`; `err_count`=1; `locked` stays 1; `expected` ends at 0x58.
- **Saturation**: ERR_WIDTH=2, locked, feed 5 non-sequential samples (0x00, 0x80, 0x40, 0xC0, 0x10) → 5 pulses; `err_count` stops at 3.
- **Auto-relock**: LOSS_THRESHOLD=3, locked, feed 0x00, 0x80, 0x40.
  - With `COUNT_CHECK_AUTORELOCK_EN`: `locked` falls on the third error's edge; relock after 5 good samples.
  - Without the macro: `locked` stays 1 and `err_count`=3.
- **Clear / reset mid-operation**:
  - Assert `clear` in the same cycle as a mismatching sample → no pulse; `err_count`=0; `locked`=0.
  - Assert `rst_n`=0 asynchronously while in LOCKING → all outputs return to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/count_check_pkg.sv
// ============================================================================
// count_check_pkg : shared state encoding and parameter defaults for
//                   count_checker.   Rev 1.0
// ============================================================================
`default_nettype none

package count_check_pkg;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_LOCK_COUNT     = 4;
  localparam int DEF_ERR_WIDTH      = 8;
  localparam int DEF_LOSS_THRESHOLD = 3;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : up-counter with synchronous clear that holds at all-ones.
//               Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/count_checker.sv
// ============================================================================
// count_checker : locks onto an incrementing count stream, then flags and
//                 tallies out-of-sequence samples.  Optional auto-relock via
//                 COUNT_CHECK_AUTORELOCK_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module count_checker
  import count_check_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int LOCK_COUNT     = DEF_LOCK_COUNT,
  parameter int ERR_WIDTH      = DEF_ERR_WIDTH,
  parameter int LOSS_THRESHOLD = DEF_LOSS_THRESHOLD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 sample_en,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [WIDTH-1:0]     expected
);

  localparam int               MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0]   s_count_q;
  logic               s_valid_q;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic               err_pulse_q, err_pulse_d;
  state_e             state_q, state_d;

  logic step_ok;
  logic lock_hit;
  logic mismatch;
  logic loss_hit;

  assign step_ok  = (s_count_q == prev_q + ONE);
  assign lock_hit = step_ok && (match_cnt_q == MATCH_W'(LOCK_COUNT - 1));
  assign mismatch = s_valid_q && (state_q == LOCKED) && (s_count_q != expected_q);

`ifdef COUNT_CHECK_AUTORELOCK_EN
  localparam int MISS_W = $clog2(LOSS_THRESHOLD + 1);

  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;

  assign loss_hit = mismatch && (miss_cnt_q == MISS_W'(LOSS_THRESHOLD - 1));

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (clear) begin
      miss_cnt_d = '0;
    end else if (s_valid_q && (state_q == LOCKED)) begin
      if (!mismatch || loss_hit) begin
        miss_cnt_d = '0;
      end else begin
        miss_cnt_d = miss_cnt_q + MISS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end
`else
  assign loss_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_count_q   <= '0;
      s_valid_q   <= 1'b0;
      prev_q      <= '0;
      expected_q  <= '0;
      match_cnt_q <= '0;
      err_pulse_q <= 1'b0;
      state_q     <= SEARCH;
    end else begin
      s_count_q   <= count_in;
      s_valid_q   <= sample_en;
      prev_q      <= prev_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      err_pulse_q <= err_pulse_d;
      state_q     <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = SEARCH;
    end else if (s_valid_q) begin
      unique case (state_q)
        SEARCH:  state_d = LOCKING;
        LOCKING: if (lock_hit) state_d = LOCKED;
        LOCKED:  if (loss_hit) state_d = SEARCH;
        default: state_d = SEARCH;
      endcase
    end
  end

  // Once locked, expected always resyncs to the received value so a glitch costs one error.
  always_comb begin
    prev_d      = prev_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    err_pulse_d = 1'b0;
    if (clear) begin
      match_cnt_d = '0;
    end else if (s_valid_q) begin
      unique case (state_q)
        SEARCH: begin
          prev_d      = s_count_q;
          match_cnt_d = '0;
        end
        LOCKING: begin
          prev_d      = s_count_q;
          match_cnt_d = (step_ok && !lock_hit) ? match_cnt_q + MATCH_W'(1) : '0;
          if (lock_hit) expected_d = s_count_q + ONE;
        end
        LOCKED: begin
          expected_d  = s_count_q + ONE;
          err_pulse_d = mismatch;
        end
        default: match_cnt_d = '0;
      endcase
    end
  end

  always_comb begin
    locked    = (state_q == LOCKED);
    err_pulse = err_pulse_q;
    expected  = expected_q;
  end

  sat_counter #(
    .WIDTH (ERR_WIDTH)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (mismatch && !clear),
    .count (err_count)
  );

endmodule

`default_nettype wire
